// File: rtl/mem_line_adapter_pkg.sv
// Shared LC-3b memory types, adapter FSM state encodings and the byte-enable merge helper.
// Imported by the line buffer and the adapter top.
package mem_line_adapter_pkg;
  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;

  typedef logic [15:0]                lc3b_word;
  typedef logic [1:0]                 lc3b_mem_wmask;
  typedef logic [LINE_BITS-1:0]       lc3b_line;
  typedef logic [15-OFFSET_BITS:0]    lc3b_line_tag;
  typedef logic [1:0]                 adapter_state_t;

  localparam adapter_state_t ST_IDLE  = 2'd0;
  localparam adapter_state_t ST_FETCH = 2'd1;
  localparam adapter_state_t ST_WRITE = 2'd2;
  localparam adapter_state_t ST_RESP  = 2'd3;

  // Overlay the enabled bytes of one word onto a line; other bytes pass through.
  function automatic lc3b_line merge_word(input lc3b_line line, input logic [2:0] idx,
                                          input lc3b_word wdata, input lc3b_mem_wmask be);
    lc3b_line r;
    r = line;
    if (be[0]) r[{idx, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) r[{idx, 4'b1000} +: 8] = wdata[15:8];
    return r;
  endfunction
endpackage

// File: rtl/mem_line_adapter_line_buffer.sv
// One-line buffer: valid/tag/data registers, hit compare, word select and byte merge.
// A load and a merge in the same cycle merge on top of the freshly loaded line.
module mem_line_adapter_line_buffer
  import mem_line_adapter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  lc3b_line_tag i_lookup_tag,
  input  logic         i_load,
  input  lc3b_line_tag i_load_tag,
  input  lc3b_line     i_load_data,
  input  logic         i_merge,
  input  logic [2:0]   i_merge_idx,
  input  lc3b_word     i_merge_data,
  input  lc3b_mem_wmask i_merge_be,
  input  logic [2:0]   i_sel_idx,
  output logic         o_hit,
  output lc3b_word     o_word,
  output lc3b_line     o_data
);
  logic         r_valid;
  lc3b_line_tag r_tag;
  lc3b_line     r_data;
  lc3b_line     w_base;
  lc3b_line     w_next_data;

  assign w_base      = i_load ? i_load_data : r_data;
  assign w_next_data = i_merge ? merge_word(w_base, i_merge_idx, i_merge_data, i_merge_be)
                               : w_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_tag;
    end
  end

  // Data carries no reset; it is only meaningful while r_valid is set.
  always_ff @(posedge clk) begin
    if (i_load || i_merge) r_data <= w_next_data;
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_word = r_data[{i_sel_idx, 4'b0000} +: 16];
  assign o_data = r_data;
endmodule

// File: rtl/mem_line_adapter.sv
// Adapts held CPU word requests to 128-bit line reads/writes with a one-line read buffer.
// Writes are read-modify-write and always written through to physical memory.
module mem_line_adapter
  import mem_line_adapter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     mem_byte_enable,
  input  logic [15:0]    mem_address,
  input  logic [15:0]    mem_wdata,
  output logic           mem_resp,
  output logic [15:0]    mem_rdata,
  output logic           pmem_read,
  output logic           pmem_write,
  output logic [15:0]    pmem_address,
  output logic [127:0]   pmem_wdata,
  input  logic [127:0]   pmem_rdata,
  input  logic           pmem_resp,
  output logic [1:0]     o_dbg_state
);
  // CPU side: mem_read/mem_write are held by the CPU until mem_resp pulses.
  // Memory side: pmem_read/pmem_write are held by us until pmem_resp.
  adapter_state_t r_state;
  logic           r_is_write;
  logic [15:0]    r_addr;
  logic [15:0]    r_wdata;
  logic [1:0]     r_be;

  logic           w_hit;
  logic           w_load;
  logic           w_merge;
  logic           w_idle_write_hit;
  logic [2:0]     w_merge_idx;
  lc3b_word       w_merge_data;
  lc3b_mem_wmask  w_merge_be;
  lc3b_word       w_buf_word;
  lc3b_line       w_buf_data;

  assign w_idle_write_hit = (r_state == ST_IDLE) && mem_write &&
                            (mem_byte_enable != 2'b00) && w_hit;
  assign w_load  = (r_state == ST_FETCH) && pmem_resp;
  assign w_merge = w_idle_write_hit || (w_load && r_is_write);

  // In IDLE the merge uses live inputs; after a fetch it uses the latched request.
  assign w_merge_idx  = (r_state == ST_IDLE) ? mem_address[3:1] : r_addr[3:1];
  assign w_merge_data = (r_state == ST_IDLE) ? mem_wdata        : r_wdata;
  assign w_merge_be   = (r_state == ST_IDLE) ? mem_byte_enable  : r_be;

  mem_line_adapter_line_buffer u_line_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lookup_tag (mem_address[15:4]),
    .i_load       (w_load),
    .i_load_tag   (r_addr[15:4]),
    .i_load_data  (pmem_rdata),
    .i_merge      (w_merge),
    .i_merge_idx  (w_merge_idx),
    .i_merge_data (w_merge_data),
    .i_merge_be   (w_merge_be),
    .i_sel_idx    (r_addr[3:1]),
    .o_hit        (w_hit),
    .o_word       (w_buf_word),
    .o_data       (w_buf_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_write || mem_read) begin
            r_is_write <= mem_write;
            r_addr     <= mem_address;
            r_wdata    <= mem_wdata;
            r_be       <= mem_byte_enable;
          end
          if (mem_write) begin
            if (mem_byte_enable == 2'b00) r_state <= ST_RESP;
            else if (w_hit)               r_state <= ST_WRITE;
            else                          r_state <= ST_FETCH;
          end else if (mem_read) begin
            r_state <= w_hit ? ST_RESP : ST_FETCH;
          end
        end
        ST_FETCH: if (pmem_resp) r_state <= r_is_write ? ST_WRITE : ST_RESP;
        ST_WRITE: if (pmem_resp) r_state <= ST_RESP;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign pmem_read    = (r_state == ST_FETCH);
  assign pmem_write   = (r_state == ST_WRITE);
  assign mem_resp     = (r_state == ST_RESP);
  assign pmem_address = {r_addr[15:4], 4'b0000};
  assign pmem_wdata   = w_buf_data;
  assign mem_rdata    = w_buf_word;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed bench for mem_line_adapter: a vector table of CPU operations against a
// small line-memory responder, plus hand sequences for reset abort and read+write.
module tb_mem_line_adapter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_line_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .o_dbg_state(dbg_state)
  );

  // Line memory responder: pmem_resp three cycles into each strobe, for one cycle.
  logic [127:0] mem_lines [logic [11:0]];
  logic [127:0] last_wline;
  logic [15:0]  last_paddr;
  int           n_reads = 0;
  int           n_writes = 0;
  int           wait_cnt = 0;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    last_wline = '0;
    last_paddr = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if (pmem_read || pmem_write) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          pmem_resp  = 1'b1;
          last_paddr = pmem_address;
          if (pmem_read) begin
            pmem_rdata = mem_lines.exists(pmem_address[15:4]) ? mem_lines[pmem_address[15:4]] : '0;
            n_reads++;
          end else begin
            mem_lines[pmem_address[15:4]] = pmem_wdata;
            last_wline = pmem_wdata;
            n_writes++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output int cycles, output logic got);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_byte_enable = be;
    got = 1'b0; cycles = 0; rdata = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (mem_resp) begin
        got = 1'b1;
        rdata = mem_rdata;
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        chk_rdata;
    logic [15:0] exp_rdata;
    int          exp_cycles;
    int          exp_dr;
    int          exp_dw;
    logic [15:0] exp_paddr;
    logic        chk_wl;
    logic [2:0]  wl_idx;
    logic [15:0] exp_wl_word;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] rdata;
    int          cycles;
    logic        got;
    int          r0, w0;
    logic [127:0] wl;
    r0 = n_reads; w0 = n_writes;
    cpu_op(v.rd, v.wr, v.addr, v.wdata, v.be, rdata, cycles, got);
    chk($sformatf("v%0d_resp", id), got, 1'b1);
    chk($sformatf("v%0d_latency", id), cycles, v.exp_cycles);
    if (v.chk_rdata) chk($sformatf("v%0d_rdata", id), rdata, v.exp_rdata);
    chk($sformatf("v%0d_pmem_reads", id), n_reads - r0, v.exp_dr);
    chk($sformatf("v%0d_pmem_writes", id), n_writes - w0, v.exp_dw);
    if (v.exp_dr + v.exp_dw > 0) chk($sformatf("v%0d_paddr", id), last_paddr, v.exp_paddr);
    if (v.chk_wl) begin
      wl = last_wline;
      chk($sformatf("v%0d_wline", id), wl[{v.wl_idx, 4'b0000} +: 16], v.exp_wl_word);
    end
    @(negedge clk);
    chk($sformatf("v%0d_single_pulse", id), mem_resp, 1'b0);
  endtask

  initial begin
    logic [127:0] line;
    logic [15:0]  rdata;
    int           cycles;
    logic         got;
    int           r0, w0;

    for (int i = 0; i < 8; i++) line[i*16 +: 16] = 16'hA000 + 16'(i);
    line[16 +: 16]  = 16'hBEEF;
    line[112 +: 16] = 16'h7777;
    mem_lines[12'h100] = line;
    mem_lines[12'h200] = {8{16'h5555}};

    //            rd  wr  addr      wdata     be     chkrd exp_rd   cyc dr dw paddr    chkwl idx wlword
    vecs[0] = '{1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 4, 1, 0, 16'h1000, 1'b0, 3'd0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h100E, 16'h0000, 2'b00, 1'b1, 16'h7777, 1, 0, 0, 16'h0000, 1'b0, 3'd0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 16'h1004, 16'h12AB, 2'b01, 1'b0, 16'h0000, 4, 0, 1, 16'h1000, 1'b1, 3'd2, 16'hA0AB};
    vecs[3] = '{1'b1, 1'b0, 16'h1004, 16'h0000, 2'b00, 1'b1, 16'hA0AB, 1, 0, 0, 16'h0000, 1'b1, 3'd1, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 16'h2000, 16'hCAFE, 2'b11, 1'b0, 16'h0000, 8, 1, 1, 16'h2000, 1'b1, 3'd0, 16'hCAFE};
    vecs[5] = '{1'b1, 1'b0, 16'h2002, 16'h0000, 2'b00, 1'b1, 16'h5555, 1, 0, 0, 16'h0000, 1'b1, 3'd1, 16'h5555};
    vecs[6] = '{1'b0, 1'b1, 16'h2006, 16'h1234, 2'b00, 1'b0, 16'h0000, 1, 0, 0, 16'h0000, 1'b0, 3'd0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h2006, 16'h0000, 2'b00, 1'b1, 16'h5555, 1, 0, 0, 16'h0000, 1'b0, 3'd0, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 16'h1004, 16'h0000, 2'b00, 1'b1, 16'hA0AB, 4, 1, 0, 16'h1000, 1'b0, 3'd0, 16'h0000};
    vecs[9] = '{1'b0, 1'b1, 16'h1008, 16'h9911, 2'b10, 1'b0, 16'h0000, 4, 0, 1, 16'h1000, 1'b1, 3'd4, 16'h9904};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_address = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_mem_resp", mem_resp, 1'b0);
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_write", pmem_write, 1'b0);
    chk("reset_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Read and write together on a hit: the write wins.
    r0 = n_reads; w0 = n_writes;
    cpu_op(1'b1, 1'b1, 16'h100C, 16'h4321, 2'b11, rdata, cycles, got);
    chk("rw_both_resp", got, 1'b1);
    chk("rw_both_latency", cycles, 4);
    chk("rw_both_writes", n_writes - w0, 1);
    chk("rw_both_reads", n_reads - r0, 0);
    chk("rw_both_wline", last_wline[96 +: 16], 16'h4321);

    // Reset during FETCH aborts the request; the old line must then miss.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h3000;
    @(negedge clk);
    chk("abort_in_fetch", pmem_read, 1'b1);
    chk("abort_paddr", pmem_address, 16'h3000);
    rst_n = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("abort_pmem_read_drop", pmem_read, 1'b0);
    chk("abort_no_resp", mem_resp, 1'b0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_late_resp", mem_resp, 1'b0);
    end
    r0 = n_reads;
    cpu_op(1'b1, 1'b0, 16'h100C, 16'h0000, 2'b00, rdata, cycles, got);
    chk("post_reset_resp", got, 1'b1);
    chk("post_reset_miss", n_reads - r0, 1);
    chk("post_reset_latency", cycles, 4);
    chk("post_reset_rdata", rdata, 16'h4321);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
